// File: rtl/inv_revaluate_unit_if.sv
// Handshake and data bus between the decoder pipeline and the inverse chi stage.
interface inv_revaluate_unit_if #(
  parameter int ROWS = 64
);
  logic              start;
  logic [5*ROWS-1:0] data_in;
  logic              ready;
  logic              busy;
  logic [5*ROWS-1:0] data_out;
  logic              out_valid;

  modport master (
    output start,
    output data_in,
    input  ready,
    input  busy,
    input  data_out,
    input  out_valid
  );

  modport slave (
    input  start,
    input  data_in,
    output ready,
    output busy,
    output data_out,
    output out_valid
  );
endinterface

// File: rtl/inv_revaluate_unit.sv
// Inverse chi stage: latches a 5-lane state slice, then recovers one 5-bit
// row per cycle through a constant inverse table, pulsing out_valid when done.
module inv_revaluate_unit #(
  parameter int ROWS = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  inv_revaluate_unit_if.slave  bus
);
  localparam int CW = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] PROC = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  // Forward chi on one row: b[i] = a[i] ^ (~a[i+1] & a[i+2]), indices mod 5.
  function automatic logic [4:0] chi_row(input logic [4:0] a);
    logic [4:0] b;
    for (int unsigned i = 0; i < 5; i++) begin
      b[i] = a[i] ^ (~a[(i + 1) % 5] & a[(i + 2) % 5]);
    end
    return b;
  endfunction

  // Inverse table built at elaboration by scattering every a to slot chi(a);
  // chi is a bijection on 5 bits, so every slot is written exactly once.
  function automatic logic [159:0] build_inv();
    logic [159:0] tbl;
    tbl = '0;
    for (int unsigned a = 0; a < 32; a++) begin
      tbl[5 * int'(chi_row(5'(a))) +: 5] = 5'(a);
    end
    return tbl;
  endfunction

  localparam logic [159:0] INV = build_inv();

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic [CW-1:0]     cnt;
  logic [5*ROWS-1:0] in_reg;
  logic [5*ROWS-1:0] result;
  logic [4:0]        row_in;
  logic [4:0]        row_out;
  logic              last_row;

  assign last_row = (cnt == CW'(ROWS - 1));

  // Select the current row and look up its inverse.
  always_comb begin
    row_in  = in_reg[5 * int'(cnt) +: 5];
    row_out = INV[5 * int'(row_in) +: 5];
  end

  // Next-state logic; any unexpected encoding falls back to IDLE.
  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE:    state_next = bus.start ? LOAD : IDLE;
      LOAD:    state_next = PROC;
      PROC:    state_next = last_row ? DONE : PROC;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Present-state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Datapath: latch input in LOAD, write one recovered row per PROC cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      in_reg <= '0;
      result <= '0;
    end else begin
      case (state)
        LOAD: begin
          in_reg <= bus.data_in;
          cnt    <= '0;
        end
        PROC: begin
          result[5 * int'(cnt) +: 5] <= row_out;
          if (!last_row) cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.ready     = (state == IDLE);
  assign bus.busy      = (state == LOAD) || (state == PROC);
  assign bus.out_valid = (state == DONE);
  assign bus.data_out  = result;
endmodule

// File: tb/tb_inv_revaluate_unit.sv
// Self-checking bench for inv_revaluate_unit: random and directed slices are
// compared against a brute-force inverse of the chi row map.
module tb_inv_revaluate_unit;
  localparam int ROWS = 64;
  localparam int W    = 5 * ROWS;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  inv_revaluate_unit_if #(.ROWS(ROWS)) bus ();

  inv_revaluate_unit #(.ROWS(ROWS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference: forward chi on a row.
  function automatic logic [4:0] chi_ref(input logic [4:0] a);
    logic [4:0] b;
    for (int i = 0; i < 5; i++) b[i] = a[i] ^ ((~a[(i + 1) % 5]) & a[(i + 2) % 5]);
    return b;
  endfunction

  // Reference inverse: exhaustive search for the preimage.
  function automatic logic [4:0] inv_ref(input logic [4:0] b);
    logic [4:0] r;
    r = '0;
    for (int a = 0; a < 32; a++) if (chi_ref(5'(a)) == b) r = 5'(a);
    return r;
  endfunction

  function automatic logic [W-1:0] chi_vec(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int k = 0; k < ROWS; k++) r[5*k +: 5] = chi_ref(v[5*k +: 5]);
    return r;
  endfunction

  function automatic logic [W-1:0] inv_vec(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int k = 0; k < ROWS; k++) r[5*k +: 5] = inv_ref(v[5*k +: 5]);
    return r;
  endfunction

  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] r;
    for (int j = 0; j < W / 32; j++) r[32*j +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [W-1:0] fill_rows(input logic [4:0] v);
    logic [W-1:0] r;
    for (int k = 0; k < ROWS; k++) r[5*k +: 5] = v;
    return r;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One operation: start raised at a negedge, then ROWS+8 cycles observed.
  // With disturb set, start is pulsed in LOAD/PROC/DONE and data_in is
  // changed right after the LOAD cycle; none of it may affect the result.
  task automatic run_op(input string tag, input logic [W-1:0] din, input bit disturb,
                        output logic [W-1:0] captured);
    int busy_cnt, ov_cnt, ov_k;
    logic ready_after;
    busy_cnt = 0; ov_cnt = 0; ov_k = -1; ready_after = 1'b0;
    captured = '0;
    @(negedge clk);
    check({tag, " ready_idle"}, W'(bus.ready), W'(1));
    bus.data_in = din;
    bus.start   = 1'b1;
    for (int k = 1; k <= ROWS + 8; k++) begin
      @(negedge clk);
      if (bus.busy) busy_cnt++;
      if (bus.out_valid) begin
        ov_cnt++;
        if (ov_k < 0) begin
          ov_k = k;
          captured = bus.data_out;
        end
      end
      if (k == ROWS + 3) ready_after = bus.ready;
      if (!disturb) begin
        if (k == 1) bus.start = 1'b0;
      end else begin
        if (k == 2) begin
          bus.start   = 1'b0;
          bus.data_in = ~din;
        end
        if (k == 30)       bus.start = 1'b1;
        if (k == 31)       bus.start = 1'b0;
        if (k == ROWS + 2) bus.start = 1'b1;
        if (k == ROWS + 3) bus.start = 1'b0;
      end
    end
    check({tag, " busy_cycles"}, W'(busy_cnt), W'(ROWS + 1));
    check({tag, " ov_latency"}, W'(ov_k), W'(ROWS + 2));
    check({tag, " ov_count"}, W'(ov_cnt), W'(1));
    check({tag, " ready_after"}, W'(ready_after), W'(1));
    check({tag, " data"}, captured, inv_vec(din));
    check({tag, " data_hold"}, bus.data_out, inv_vec(din));
  endtask

  initial begin
    logic [W-1:0] v, cap;
    int ov_seen, ready_cnt, ov_k [3];

    bus.start   = 1'b0;
    bus.data_in = '0;
    rst = 1'b1;
    #1;
    check("rst ready", W'(bus.ready), W'(1));
    check("rst busy", W'(bus.busy), W'(0));
    check("rst out_valid", W'(bus.out_valid), W'(0));
    check("rst data_out", bus.data_out, '0);
    @(negedge clk);
    rst = 1'b0;

    // Anchor patterns over the whole slice.
    run_op("all09", fill_rows(5'h09), 1'b0, cap);
    check("all09 rows=01", cap, fill_rows(5'h01));
    run_op("all1F", fill_rows(5'h1F), 1'b0, cap);
    check("all1F rows=1F", cap, fill_rows(5'h1F));
    run_op("all12", fill_rows(5'h12), 1'b0, cap);
    check("all12 rows=02", cap, fill_rows(5'h02));

    // Round trip of every row value through row 0.
    for (int r = 0; r < 32; r++) begin
      v = rand_vec();
      v[4:0] = chi_ref(5'(r));
      run_op($sformatf("rt%0d", r), v, 1'b0, cap);
      check($sformatf("rt%0d row0", r), W'(cap[4:0]), W'(r));
    end

    // Random full vectors through chi then this block.
    for (int n = 0; n < 4; n++) begin
      v = rand_vec();
      run_op($sformatf("rand%0d", n), chi_vec(v), 1'b0, cap);
      check($sformatf("rand%0d roundtrip", n), cap, v);
    end

    // Spurious start pulses and a data_in change after LOAD.
    v = rand_vec();
    run_op("disturb", v, 1'b1, cap);

    // Asynchronous reset mid-cycle at PROC row 30.
    v = rand_vec();
    @(negedge clk);
    bus.data_in = v;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (31) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst ready", W'(bus.ready), W'(1));
    check("midrst busy", W'(bus.busy), W'(0));
    check("midrst out_valid", W'(bus.out_valid), W'(0));
    check("midrst data_out", bus.data_out, '0);
    @(negedge clk);
    rst = 1'b0;
    ov_seen = 0;
    repeat (ROWS + 4) begin
      @(negedge clk);
      if (bus.out_valid) ov_seen++;
    end
    check("midrst no_ov", W'(ov_seen), W'(0));
    run_op("after_rst", v, 1'b0, cap);

    // start held high: three back-to-back operations.
    v = rand_vec();
    @(negedge clk);
    bus.data_in = v;
    bus.start   = 1'b1;
    ov_seen = 0; ready_cnt = 0;
    for (int i = 0; i < 3; i++) ov_k[i] = -1;
    for (int k = 1; k <= 3 * (ROWS + 3) + 10; k++) begin
      @(negedge clk);
      if (ov_seen < 3 && bus.ready) ready_cnt++;
      if (bus.out_valid && ov_seen < 3) begin
        ov_k[ov_seen] = k;
        check($sformatf("held op%0d data", ov_seen), bus.data_out, inv_vec(v));
        ov_seen++;
        if (ov_seen == 3) bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    check("held ov_count", W'(ov_seen), W'(3));
    check("held gap1", W'(ov_k[1] - ov_k[0]), W'(ROWS + 3));
    check("held gap2", W'(ov_k[2] - ov_k[1]), W'(ROWS + 3));
    check("held ready_cycles", W'(ready_cnt), W'(2));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
